// File: rtl/rv32v_types_pkg.sv
// Shared vector pipeline types: functional units, ALU ops,
// element width, LMUL and the decode->execute control bundle.
package rv32v_types_pkg;

  typedef enum logic [2:0] {
    FU_ALU  = 3'd0,
    FU_MUL  = 3'd1,
    FU_DIV  = 3'd2,
    FU_LSU  = 3'd3,
    FU_PERM = 3'd4,
    FU_RED  = 3'd5
  } fu_t;

  typedef enum logic [4:0] {
    VADD   = 5'd0,
    VSUB   = 5'd1,
    VAND   = 5'd2,
    VOR    = 5'd3,
    VXOR   = 5'd4,
    VSLL   = 5'd5,
    VSRL   = 5'd6,
    VSRA   = 5'd7,
    VMIN   = 5'd8,
    VMAX   = 5'd9,
    VMUL   = 5'd10,
    VMERGE = 5'd11
  } valuop_t;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef enum logic [2:0] {
    LMUL1  = 3'd0,
    LMUL2  = 3'd1,
    LMUL4  = 3'd2,
    LMUL8  = 3'd3,
    LMULF8 = 3'd5,
    LMULF4 = 3'd6,
    LMULF2 = 3'd7
  } vlmul_t;

  typedef struct packed {
    fu_t         fu_type;
    valuop_t     aluop;
    logic [4:0]  vd;
    sew_t        sew;
    vlmul_t      lmul;
    logic        is_masked;
    logic        vd_widen;
    logic        vd_narrow;
    logic        rd_wen;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
  } de_ctrl_t;

endpackage

// File: rtl/rv32v_lane_enable.sv
// Resolves per-lane write enables and the last-beat flag.
// Ports: req/mask lane bits, is_masked, eidx, vl -> en, last.
module rv32v_lane_enable
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] mask,
  input  logic                 is_masked,
  input  logic [31:0]          eidx,
  input  logic [31:0]          vl,
  output logic [NUM_LANES-1:0] en,
  output logic                 last
);

  // 33-bit math so eidx near 2^32 cannot wrap below vl.
  logic [32:0] base;
  logic [32:0] lim;

  assign base = {1'b0, eidx};
  assign lim  = {1'b0, vl};

  always_comb begin
    en = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      en[l] = req[l]
            & ((base + 33'(l)) < lim)
            & (~is_masked | mask[l]);
    end
  end

  // vl = 0 satisfies this trivially.
  assign last = (base + 33'(NUM_LANES)) >= lim;

endmodule

// File: rtl/rv32v_de_pipe_reg.sv
// Elastic decode->execute FIFO with flush and lane enables.
// Ports: in_* beat + valid/ready, out_* head + valid/ready, count.
module rv32v_de_pipe_reg
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  de_ctrl_t                      in_ctrl,
  input  logic [NUM_LANES*DATA_W-1:0]   in_vs1,
  input  logic [NUM_LANES*DATA_W-1:0]   in_vs2,
  input  logic [NUM_LANES*DATA_W-1:0]   in_vs3,
  input  logic [NUM_LANES-1:0]          in_wen,
  input  logic [NUM_LANES-1:0]          in_mask,
  input  logic [31:0]                   in_eidx,
  input  logic [31:0]                   in_vl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output de_ctrl_t                      out_ctrl,
  output logic [NUM_LANES*DATA_W-1:0]   out_vs1,
  output logic [NUM_LANES*DATA_W-1:0]   out_vs2,
  output logic [NUM_LANES*DATA_W-1:0]   out_vs3,
  output logic [NUM_LANES-1:0]          out_wen,
  output logic                          out_last,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = NUM_LANES * DATA_W;

  de_ctrl_t             ctrl_q [DEPTH];
  logic [VW-1:0]        vs1_q  [DEPTH];
  logic [VW-1:0]        vs2_q  [DEPTH];
  logic [VW-1:0]        vs3_q  [DEPTH];
  logic [NUM_LANES-1:0] wen_q  [DEPTH];
  logic                 last_q [DEPTH];

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic [NUM_LANES-1:0] lane_en;
  logic                 lane_last;

  rv32v_lane_enable #(
    .NUM_LANES (NUM_LANES)
  ) u_lane_enable (
    .req       (in_wen),
    .mask      (in_mask),
    .is_masked (in_ctrl.is_masked),
    .eidx      (in_eidx),
    .vl        (in_vl),
    .en        (lane_en),
    .last      (lane_last)
  );

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge CLK) begin
    if (push) begin
      ctrl_q[wr_ptr] <= in_ctrl;
      vs1_q[wr_ptr]  <= in_vs1;
      vs2_q[wr_ptr]  <= in_vs2;
      vs3_q[wr_ptr]  <= in_vs3;
      wen_q[wr_ptr]  <= lane_en;
      last_q[wr_ptr] <= lane_last;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset, so mask the head while empty.
  assign out_ctrl = out_valid ? ctrl_q[rd_ptr] : '0;
  assign out_vs1  = out_valid ? vs1_q[rd_ptr]  : '0;
  assign out_vs2  = out_valid ? vs2_q[rd_ptr]  : '0;
  assign out_vs3  = out_valid ? vs3_q[rd_ptr]  : '0;
  assign out_wen  = out_valid ? wen_q[rd_ptr]  : '0;
  assign out_last = out_valid & last_q[rd_ptr];

endmodule
